vector_csr_unit: RTL and testbench

Parametrised vector CSR unit for the VPU. It holds vstart, vxsat, vxrm, vl, vtype and vlenb, and serves the core's CSR read/write port. It executes vsetvl/vsetvli/vsetivli through a two-cycle valid/ready handshake, computing VLMAX from SEW, LMUL and VLEN and flagging illegal vtype settings. Its vsew/vlmul/vta/vma/vill/vl outputs feed the vector datapath and sequencer.

---
 rtl/vpu_csr_pkg.sv | 31 +++
 rtl/vlmax_calc.sv | 47 ++++
 rtl/vector_csr_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_vector_csr_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_csr_pkg.sv
// Shared definitions for the vector CSR unit: CSR addresses, CSR op encoding,
// vset FSM states and vtype field positions.
package vpu_csr_pkg;

  localparam logic [11:0] CsrVstart = 12'h008;
  localparam logic [11:0] CsrVxsat  = 12'h009;
  localparam logic [11:0] CsrVxrm   = 12'h00A;
  localparam logic [11:0] CsrVcsr   = 12'h00F;
  localparam logic [11:0] CsrVl     = 12'hC20;
  localparam logic [11:0] CsrVtype  = 12'hC21;
  localparam logic [11:0] CsrVlenb  = 12'hC22;

  typedef enum logic [1:0] {
    CsrOpRead  = 2'b00,
    CsrOpWrite = 2'b01,
    CsrOpSet   = 2'b10,
    CsrOpClear = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StCommit
  } vset_state_e;

  localparam int unsigned VtypeVlmulLsb = 0;
  localparam int unsigned VtypeVsewLsb  = 3;
  localparam int unsigned VtypeVtaBit   = 6;
  localparam int unsigned VtypeVmaBit   = 7;

endpackage

// File: rtl/vlmax_calc.sv
// Combinational VLMAX and vill from vsew/vlmul/reserved-bit flag.
// Fractional LMUL (vlmul 5/6/7) is legal only when VCSR_FRAC_LMUL_EN is defined.
module vlmax_calc #(
  parameter int unsigned VLEN = 256,
  parameter int unsigned ELEN = 32,
  localparam int unsigned VW  = $clog2(VLEN) + 4
) (
  input  logic [2:0]    vsew,
  input  logic [2:0]    vlmul,
  input  logic          rsvd_nz,
  output logic [VW-1:0] vlmax,
  output logic          vill
);

  logic [31:0]   sew;
  logic [VW-1:0] base;
`ifdef VCSR_FRAC_LMUL_EN
  logic [2:0]    frac_shift;
`endif

  always_comb begin
    sew   = 32'd8 << vsew;
    base  = VW'(VLEN >> (3 + vsew));
    vlmax = '0;
    vill  = rsvd_nz || vsew[2] || (sew > ELEN);
`ifdef VCSR_FRAC_LMUL_EN
    // 7/6/5 map to right shifts of 1/2/3, i.e. 8 - vlmul modulo 8.
    frac_shift = 3'd0 - vlmul;
`endif
    case (vlmul)
      3'd0, 3'd1, 3'd2, 3'd3: vlmax = base << vlmul[1:0];
      3'd5, 3'd6, 3'd7: begin
`ifdef VCSR_FRAC_LMUL_EN
        vlmax = base >> frac_shift;
        vill  = vill || (sew > (ELEN >> frac_shift));
`else
        vill  = 1'b1;
`endif
      end
      default: vill = 1'b1;
    endcase
    if (vill) begin
      vlmax = '0;
    end
  end

endmodule

// File: rtl/vector_csr_unit.sv
// Vector CSR unit: vstart/vxsat/vxrm/vl/vtype/vlenb and the vsetvl FSM.
// Optional fractional LMUL support via VCSR_FRAC_LMUL_EN (applied in vlmax_calc).
module vector_csr_unit
  import vpu_csr_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned VLEN  = 256,
  parameter int unsigned ELEN  = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vset_valid,
  output logic             o_vset_ready,
  input  logic [WIDTH-1:0] i_vtype,
  input  logic [WIDTH-1:0] i_avl,
  input  logic             i_rs1_x0,
  input  logic             i_rd_x0,
  output logic             o_vset_done,
  output logic [WIDTH-1:0] o_vl,
  input  logic             i_csr_en,
  input  logic [11:0]      i_csr_addr,
  input  logic [1:0]       i_csr_op,
  input  logic [WIDTH-1:0] i_csr_wdata,
  output logic [WIDTH-1:0] o_csr_rdata,
  output logic             o_csr_err,
  input  logic             i_vxsat_set,
  input  logic             i_vstart_wen,
  input  logic [WIDTH-1:0] i_vstart,
  output logic [2:0]       o_vsew,
  output logic [2:0]       o_vlmul,
  output logic             o_vta,
  output logic             o_vma,
  output logic             o_vill,
  output logic [WIDTH-1:0] o_vstart,
  output logic [1:0]       o_vxrm
);

  localparam int unsigned VW = $clog2(VLEN) + 4;
  localparam logic [WIDTH-1:0] VtypeIll = {1'b1, {(WIDTH-1){1'b0}}};

  vset_state_e state_q, state_d;

  logic [WIDTH-2:0] req_vtype_q;
  logic [WIDTH-1:0] req_avl_q;
  logic             req_rs1_x0_q, req_rd_x0_q;
  logic [VW-1:0]    vlmax_q, calc_vlmax;
  logic             vill_q, calc_vill;
  logic             done_q;

  logic [WIDTH-1:0] vl_q, vl_d;
  logic [WIDTH-1:0] vtype_q, vtype_d;
  logic [WIDTH-1:0] vstart_q, vstart_d;
  logic             vxsat_q, vxsat_d;
  logic [1:0]       vxrm_q, vxrm_d;

  logic             commit;
  logic [WIDTH-1:0] vlmax_ext;
  logic             addr_ok, read_only, csr_wen;
  logic [WIDTH-1:0] csr_result;

  // The vill bit of a requested vtype carries no meaning and is ignored.
  logic unused_vtype_msb;
  assign unused_vtype_msb = i_vtype[WIDTH-1];

  vlmax_calc #(
    .VLEN(VLEN),
    .ELEN(ELEN)
  ) u_vlmax_calc (
    .vsew   (req_vtype_q[VtypeVsewLsb +: 3]),
    .vlmul  (req_vtype_q[VtypeVlmulLsb +: 3]),
    .rsvd_nz(|req_vtype_q[WIDTH-2:8]),
    .vlmax  (calc_vlmax),
    .vill   (calc_vill)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (i_vset_valid) state_d = StCalc;
      StCalc:   state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign o_vset_ready = (state_q == StIdle);
  assign commit       = (state_q == StCommit);
  assign vlmax_ext    = WIDTH'(vlmax_q);

  // CSR read decode; unused bits stay zero so set/clear results need no masking.
  always_comb begin
    o_csr_rdata = '0;
    addr_ok     = 1'b1;
    read_only   = 1'b0;
    case (i_csr_addr)
      CsrVstart: o_csr_rdata = vstart_q;
      CsrVxsat:  o_csr_rdata[0] = vxsat_q;
      CsrVxrm:   o_csr_rdata[1:0] = vxrm_q;
      CsrVcsr:   o_csr_rdata[2:0] = {vxrm_q, vxsat_q};
      CsrVl: begin
        o_csr_rdata = vl_q;
        read_only   = 1'b1;
      end
      CsrVtype: begin
        o_csr_rdata = vtype_q;
        read_only   = 1'b1;
      end
      CsrVlenb: begin
        o_csr_rdata = WIDTH'(VLEN / 8);
        read_only   = 1'b1;
      end
      default: addr_ok = 1'b0;
    endcase
  end

  assign o_csr_err = i_csr_en && (!addr_ok || (read_only && (i_csr_op != CsrOpRead)));
  assign csr_wen   = i_csr_en && !o_csr_err && (i_csr_op != CsrOpRead);

  always_comb begin
    case (i_csr_op)
      CsrOpWrite: csr_result = i_csr_wdata;
      CsrOpSet:   csr_result = o_csr_rdata | i_csr_wdata;
      CsrOpClear: csr_result = o_csr_rdata & ~i_csr_wdata;
      default:    csr_result = o_csr_rdata;
    endcase
  end

  always_comb begin
    vl_d    = vl_q;
    vtype_d = vtype_q;
    if (commit) begin
      if (vill_q) begin
        vl_d    = '0;
        vtype_d = VtypeIll;
      end else begin
        vtype_d = {{(WIDTH-8){1'b0}}, req_vtype_q[7:0]};
        if (!req_rs1_x0_q) begin
          vl_d = (req_avl_q < vlmax_ext) ? req_avl_q : vlmax_ext;
        end else if (!req_rd_x0_q) begin
          vl_d = vlmax_ext;
        end else begin
          vl_d = (vl_q < vlmax_ext) ? vl_q : vlmax_ext;
        end
      end
    end
  end

  // Priority: vset commit, then CSR write, then datapath update.
  always_comb begin
    vstart_d = vstart_q;
    vxsat_d  = vxsat_q;
    vxrm_d   = vxrm_q;
    if (commit) begin
      vstart_d = '0;
    end else if (csr_wen && (i_csr_addr == CsrVstart)) begin
      vstart_d = csr_result;
    end else if (i_vstart_wen) begin
      vstart_d = i_vstart;
    end
    if (csr_wen && (i_csr_addr == CsrVxsat)) vxsat_d = csr_result[0];
    if (csr_wen && (i_csr_addr == CsrVxrm))  vxrm_d  = csr_result[1:0];
    if (csr_wen && (i_csr_addr == CsrVcsr)) begin
      vxsat_d = csr_result[0];
      vxrm_d  = csr_result[2:1];
    end
    vxsat_d = vxsat_d | i_vxsat_set;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_vtype_q  <= '0;
      req_avl_q    <= '0;
      req_rs1_x0_q <= 1'b0;
      req_rd_x0_q  <= 1'b0;
      vlmax_q      <= '0;
      vill_q       <= 1'b0;
      done_q       <= 1'b0;
      vl_q         <= '0;
      vtype_q      <= VtypeIll;
      vstart_q     <= '0;
      vxsat_q      <= 1'b0;
      vxrm_q       <= 2'b00;
    end else begin
      if (o_vset_ready && i_vset_valid) begin
        req_vtype_q  <= i_vtype[WIDTH-2:0];
        req_avl_q    <= i_avl;
        req_rs1_x0_q <= i_rs1_x0;
        req_rd_x0_q  <= i_rd_x0;
      end
      if (state_q == StCalc) begin
        vlmax_q <= calc_vlmax;
        vill_q  <= calc_vill;
      end
      done_q   <= commit;
      vl_q     <= vl_d;
      vtype_q  <= vtype_d;
      vstart_q <= vstart_d;
      vxsat_q  <= vxsat_d;
      vxrm_q   <= vxrm_d;
    end
  end

  assign o_vset_done = done_q;
  assign o_vl        = vl_q;
  assign o_vsew      = vtype_q[VtypeVsewLsb +: 3];
  assign o_vlmul     = vtype_q[VtypeVlmulLsb +: 3];
  assign o_vta       = vtype_q[VtypeVtaBit];
  assign o_vma       = vtype_q[VtypeVmaBit];
  assign o_vill      = vtype_q[WIDTH-1];
  assign o_vstart    = vstart_q;
  assign o_vxrm      = vxrm_q;

endmodule

// File: tb/tb_vector_csr_unit.sv
// Scoreboard bench for vector_csr_unit (VLEN=256, ELEN=32): stimulus pushes expected
// vset and CSR responses, independent monitors pop and compare.
module tb_vector_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        vset_valid, vset_ready, rs1_x0, rd_x0, vset_done;
  logic [31:0] vtype, avl, vl;
  logic        csr_en, csr_err;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata, csr_rdata;
  logic        vxsat_set, vstart_wen;
  logic [31:0] vstart_in, vstart_out;
  logic [2:0]  vsew, vlmul;
  logic        vta, vma, vill;
  logic [1:0]  vxrm;

  always #5 clk = ~clk;

  vector_csr_unit #(
    .WIDTH(32),
    .VLEN (256),
    .ELEN (32)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_vset_valid(vset_valid),
    .o_vset_ready(vset_ready),
    .i_vtype     (vtype),
    .i_avl       (avl),
    .i_rs1_x0    (rs1_x0),
    .i_rd_x0     (rd_x0),
    .o_vset_done (vset_done),
    .o_vl        (vl),
    .i_csr_en    (csr_en),
    .i_csr_addr  (csr_addr),
    .i_csr_op    (csr_op),
    .i_csr_wdata (csr_wdata),
    .o_csr_rdata (csr_rdata),
    .o_csr_err   (csr_err),
    .i_vxsat_set (vxsat_set),
    .i_vstart_wen(vstart_wen),
    .i_vstart    (vstart_in),
    .o_vsew      (vsew),
    .o_vlmul     (vlmul),
    .o_vta       (vta),
    .o_vma       (vma),
    .o_vill      (vill),
    .o_vstart    (vstart_out),
    .o_vxrm      (vxrm)
  );

  typedef struct {
    string       name;
    logic [31:0] vl;
    logic        vill;
    int unsigned done_cyc;
  } vset_exp_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        chk_data;
    logic        err;
  } csr_exp_t;

  vset_exp_t vq[$];
  csr_exp_t  cq[$];
  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // vset monitor
  initial forever begin
    vset_exp_t e;
    @(negedge clk);
    if (!rst && vset_done) begin
      if (vq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = vq.pop_front();
        chk({e.name, "_vl"}, vl, e.vl);
        chk({e.name, "_vill"}, {31'd0, vill}, {31'd0, e.vill});
        chk({e.name, "_vstart"}, vstart_out, 32'd0);
        chk({e.name, "_latency"}, cyc, e.done_cyc);
      end
    end
  end

  // CSR monitor
  initial forever begin
    csr_exp_t e;
    @(negedge clk);
    if (!rst && csr_en) begin
      if (cq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL csr_no_expectation actual=access expected=none");
      end else begin
        e = cq.pop_front();
        if (e.chk_data) chk({e.name, "_rdata"}, csr_rdata, e.rdata);
        chk({e.name, "_err"}, {31'd0, csr_err}, {31'd0, e.err});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input string name, input logic [11:0] addr, input logic [1:0] op,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic chk_d,
                     input logic exp_err, input logic vx = 1'b0, input logic vs_wen = 1'b0,
                     input logic [31:0] vs = 32'd0);
    csr_en     = 1'b1;
    csr_addr   = addr;
    csr_op     = op;
    csr_wdata  = wd;
    vxsat_set  = vx;
    vstart_wen = vs_wen;
    vstart_in  = vs;
    cq.push_back('{name, exp_rd, chk_d, exp_err});
    step();
    csr_en     = 1'b0;
    vxsat_set  = 1'b0;
    vstart_wen = 1'b0;
  endtask

  task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp_rd);
    csr(name, addr, 2'b00, 32'd0, exp_rd, 1'b1, 1'b0);
  endtask

  // Waits for ready at the negedge; returns the cycle number of the accepting edge.
  task automatic wait_accept(input string name, output int unsigned acc, output bit ok);
    int n = 0;
    ok = 1'b1;
    forever begin
      @(negedge clk);
      if (vset_ready) break;
      n++;
      if (n > 20) begin
        checks++;
        failures++;
        $display("FAIL %s_accept_timeout actual=not_ready expected=ready", name);
        ok = 1'b0;
        break;
      end
    end
    acc = cyc + 1;
  endtask

  task automatic vset(input string name, input logic [31:0] vt, input logic [31:0] a,
                      input logic r1x0, input logic rdx0, input logic [31:0] exp_vl,
                      input logic exp_vill);
    int unsigned acc;
    bit ok;
    vset_valid = 1'b1;
    vtype      = vt;
    avl        = a;
    rs1_x0     = r1x0;
    rd_x0      = rdx0;
    wait_accept(name, acc, ok);
    if (ok) vq.push_back('{name, exp_vl, exp_vill, acc + 2});
    step();
    vset_valid = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    int unsigned acc1, acc2;
    bit ok1, ok2;
    int n;
    rst = 1'b1;
    vset_valid = 1'b0; vtype = '0; avl = '0; rs1_x0 = 1'b0; rd_x0 = 1'b0;
    csr_en = 1'b0; csr_addr = '0; csr_op = '0; csr_wdata = '0;
    vxsat_set = 1'b0; vstart_wen = 1'b0; vstart_in = '0;
    repeat (3) step();
    rst = 1'b0;

    rd("rst_vtype", 12'hC21, 32'h8000_0000);
    rd("rst_vl", 12'hC20, 32'd0);
    rd("rst_vlenb", 12'hC22, 32'd32);
    rd("rst_vcsr", 12'h00F, 32'd0);
    rd("rst_vstart", 12'h008, 32'd0);

    // datapath vstart update, cleared by the next commit
    vstart_wen = 1'b1; vstart_in = 32'd5;
    step();
    vstart_wen = 1'b0;
    rd("vstart_dp", 12'h008, 32'd5);

    vset("e32m1", 32'h010, 32'd10, 1'b0, 1'b0, 32'd8, 1'b0);
    rd("e32m1_vtype", 12'hC21, 32'h010);
    vset("e8m2", 32'h001, 32'd100, 1'b0, 1'b0, 32'd64, 1'b0);
    vset("e16m1", 32'h008, 32'd5, 1'b0, 1'b0, 32'd5, 1'b0);
    vset("e8m8_rs1x0", 32'h003, 32'd7, 1'b1, 1'b0, 32'd256, 1'b0);
    vset("e32m1_keep", 32'h010, 32'd0, 1'b1, 1'b1, 32'd8, 1'b0);
    vset("vlmul4", 32'h004, 32'd10, 1'b0, 1'b0, 32'd0, 1'b1);
    rd("vlmul4_vtype", 12'hC21, 32'h8000_0000);
    vset("e64", 32'h018, 32'd10, 1'b0, 1'b0, 32'd0, 1'b1);
`ifdef VCSR_FRAC_LMUL_EN
    vset("e8mf2", 32'h007, 32'd100, 1'b0, 1'b0, 32'd16, 1'b0);
`else
    vset("e8mf2", 32'h007, 32'd100, 1'b0, 1'b0, 32'd0, 1'b1);
`endif
    vset("e32mf2", 32'h017, 32'd100, 1'b0, 1'b0, 32'd0, 1'b1);
    vset("e8mf8", 32'h005, 32'd100, 1'b0, 1'b0, 32'd0, 1'b1);
    vset("rsvd", 32'h110, 32'd4, 1'b0, 1'b0, 32'd0, 1'b1);
    vset("e32m1_tama", 32'h0D0, 32'd3, 1'b0, 1'b0, 32'd3, 1'b0);
    rd("tama_vtype", 12'hC21, 32'h0D0);

    csr("vcsr_wr", 12'h00F, 2'b01, 32'h7, 32'd0, 1'b0, 1'b0);
    rd("vxrm_rd", 12'h00A, 32'd3);
    rd("vxsat_rd", 12'h009, 32'd1);
    csr("vxsat_clr_sat", 12'h009, 2'b11, 32'h1, 32'd1, 1'b1, 1'b0, 1'b1);
    rd("vxsat_sticky", 12'h009, 32'd1);
    csr("vxsat_clr", 12'h009, 2'b11, 32'h1, 32'd1, 1'b1, 1'b0);
    rd("vxsat_cleared", 12'h009, 32'd0);
    csr("vxrm_set", 12'h00A, 2'b11, 32'h1, 32'd3, 1'b1, 1'b0);
    rd("vcsr_after", 12'h00F, 32'h4);
    csr("vl_wr", 12'hC20, 2'b01, 32'd99, 32'd0, 1'b0, 1'b1);
    rd("vl_unchanged", 12'hC20, 32'd3);
    csr("vlenb_set", 12'hC22, 2'b10, 32'd1, 32'd0, 1'b0, 1'b1);
    csr("bad_addr", 12'h123, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1);
    csr("vstart_race", 12'h008, 2'b01, 32'd4, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd9);
    rd("vstart_csr_wins", 12'h008, 32'd4);

    // reset while the request sits in CALC: no commit, reset values restored
    vset_valid = 1'b1; vtype = 32'h010; avl = 32'd10; rs1_x0 = 1'b0; rd_x0 = 1'b0;
    wait_accept("rst_calc", acc1, ok1);
    step();
    vset_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    rd("rst_calc_vtype", 12'hC21, 32'h8000_0000);
    rd("rst_calc_vl", 12'hC20, 32'd0);
    rd("rst_calc_vxrm", 12'h00A, 32'd0);
    rd("rst_calc_vstart", 12'h008, 32'd0);

    // back-to-back requests, valid held high throughout
    vset_valid = 1'b1; vtype = 32'h010; avl = 32'd4;
    wait_accept("b2b_a", acc1, ok1);
    if (ok1) vq.push_back('{"b2b_a", 32'd4, 1'b0, acc1 + 2});
    step();
    avl = 32'd20;
    wait_accept("b2b_b", acc2, ok2);
    if (ok2) vq.push_back('{"b2b_b", 32'd8, 1'b0, acc2 + 2});
    if (ok1 && ok2) chk("b2b_gap", acc2 - acc1, 32'd3);
    step();
    vset_valid = 1'b0;
    repeat (3) step();

    n = 0;
    while ((vq.size() != 0 || cq.size() != 0) && n < 50) begin
      step();
      n++;
    end
    if (vq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL missing_done actual=%0d_outstanding expected=0", vq.size());
    end
    if (cq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL missing_csr actual=%0d_outstanding expected=0", cq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
